tiny_grev: RTL and testbench



---
 rtl/tiny_grev_if.sv | 10 +
 rtl/tiny_grev.sv | 66 ++++++
 tb/tb_tiny_grev.sv | 130 +++++++++++++
 3 files changed

// File: rtl/tiny_grev_if.sv
// tiny_grev_if: launch/result bundle between a core's ALU and the GREV unit
interface tiny_grev_if;
   logic        start;
   logic [31:0] rs1;
   logic [4:0]  rs2;
   logic [31:0] rd;
   logic        done;
   modport master (output start, rs1, rs2, input rd, done);
   modport slave (input start, rs1, rs2, output rd, done);
endinterface

// File: rtl/tiny_grev.sv
// tiny_grev: multi-cycle 32-bit generalized reverse, one butterfly stage per clock
module tiny_grev (
   input logic        clock,
   input logic        reset,
   tiny_grev_if.slave bus
);
   typedef enum logic {IDLE, RUN} state_t;
   state_t      state, state_n;
   logic [31:0] x, x_n, mask, stage_x;
   logic [4:0]  c, c_n, s;
   logic [2:0]  k, k_n;
   logic        done, done_n, en;

   assign bus.rd   = x;
   assign bus.done = done;

   // butterfly for stage k: swap s-bit groups selected by mask when c[k] is set
   always_comb begin
      mask    = k == 3'd0 ? 32'h5555_5555 :
                k == 3'd1 ? 32'h3333_3333 :
                k == 3'd2 ? 32'h0F0F_0F0F :
                k == 3'd3 ? 32'h00FF_00FF : 32'h0000_FFFF;
      s       = 5'd1 << k;
      en      = |(c & (5'd1 << k));
      stage_x = en ? ((x & mask) << s) | ((x >> s) & mask) : x;
   end

   // next state: start (re)loads operands from any state, RUN advances one stage per clock
   always_comb begin
      state_n = state;
      x_n     = x;
      c_n     = c;
      k_n     = k;
      done_n  = 1'b0;
      if (bus.start) begin
         state_n = RUN;
         x_n     = bus.rs1;
         c_n     = bus.rs2;
         k_n     = 3'd0;
      end else if (state == RUN) begin
         x_n = stage_x;
         k_n = k == 3'd4 ? 3'd0 : k + 3'd1;
         if (k == 3'd4) begin
            state_n = IDLE;
            done_n  = 1'b1;
         end
      end
   end

   // state registers; reset wins over start and discards any operation in flight
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         x     <= '0;
         c     <= '0;
         k     <= '0;
         done  <= 1'b0;
      end else begin
         state <= state_n;
         x     <= x_n;
         c     <= c_n;
         k     <= k_n;
         done  <= done_n;
      end
   end
endmodule

// File: tb/tb_tiny_grev.sv
// tb_tiny_grev: directed and random checks of tiny_grev against a bit-permutation model
module tb_tiny_grev;
   logic clock = 1'b0;
   logic reset = 1'b1;
   int   vecs = 0;
   int   errs = 0;

   tiny_grev_if bus ();
   tiny_grev dut (.clock(clock), .reset(reset), .bus(bus));

   always #5 clock = ~clock;

   // grev as a permutation: result bit (i xor c) takes source bit i
   function automatic logic [31:0] grev(input logic [31:0] v, input logic [4:0] c);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < 32; i++) r[i ^ int'(c)] = v[i];
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      vecs++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   // cycle model: countdown from each accepted start, result known only when idle
   int          cnt = 0;
   logic        mdone = 1'b0;
   logic        mknown = 1'b0;
   logic        armed = 1'b0;
   logic [31:0] mrd = '0;
   logic [31:0] pend = '0;
   always @(posedge clock) begin
      if (reset) begin
         cnt = 0; mdone = 1'b0; mknown = 1'b1; mrd = '0; armed = 1'b1;
      end else if (bus.start) begin
         cnt = 5; mdone = 1'b0; mknown = 1'b0; pend = grev(bus.rs1, bus.rs2);
      end else if (cnt > 0) begin
         cnt--;
         mdone = cnt == 0;
         if (cnt == 0) begin mknown = 1'b1; mrd = pend; end
      end else mdone = 1'b0;
   end

   // every-cycle compare of done, and of rd whenever the model knows it
   always @(negedge clock) if (armed) begin
      check("done", {31'd0, bus.done}, {31'd0, mdone});
      if (mknown) check("rd", bus.rd, mrd);
   end

   task automatic issue(input logic [31:0] a, input logic [4:0] b);
      bus.start = 1'b1; bus.rs1 = a; bus.rs2 = b;
      @(negedge clock);
      bus.start = 1'b0; bus.rs1 = 'x; bus.rs2 = 'x;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (!bus.done && n < 20);
   endtask

   task automatic directed(input string name, input logic [31:0] a, input logic [4:0] b, input logic [31:0] exp);
      int n;
      check({name, "_model"}, grev(a, b), exp);
      issue(a, b);
      wait_done(n);
      check({name, "_latency"}, 32'(n), 32'd5);
      check({name, "_rd"}, bus.rd, exp);
   endtask

   initial begin
      int n, pulses, pos;
      logic [31:0] a, r;
      logic [4:0]  b;
      bus.start = 1'b0; bus.rs1 = 'x; bus.rs2 = 'x;
      repeat (3) @(negedge clock);
      check("reset_rd", bus.rd, 32'd0);
      check("reset_done", {31'd0, bus.done}, 32'd0);
      reset = 1'b0;
      @(negedge clock);
      directed("bitrev", 32'h1234_5678, 5'd31, 32'h1E6A_2C48);
      directed("byteswap", 32'h1234_5678, 5'd24, 32'h7856_3412);
      directed("halfswap", 32'h1234_5678, 5'd16, 32'h5678_1234);
      directed("brev8", 32'h1234_5678, 5'd7, 32'h482C_6A1E);
      directed("identity", 32'h1234_5678, 5'd0, 32'h1234_5678);
      directed("stage0", 32'hAAAA_AAAA, 5'd1, 32'h5555_5555);
      repeat (2) @(negedge clock);
      check("retain", bus.rd, 32'h5555_5555);
      for (int i = 0; i < 1000; i++) begin
         a = $urandom; b = 5'($urandom);
         issue(a, b);
         wait_done(n);
         check("stream_latency", 32'(n), 32'd5);
         check("stream_rd", bus.rd, grev(a, b));
         repeat ($urandom_range(16, 6) - 6) @(negedge clock);
      end
      @(negedge clock);
      issue(32'hDEAD_BEEF, 5'd31);
      @(negedge clock);
      issue(32'h0123_4567, 5'd24);
      pulses = 0; pos = 0; r = '0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clock);
         if (bus.done) begin pulses++; pos = i; r = bus.rd; end
      end
      check("restart_pulses", 32'(pulses), 32'd1);
      check("restart_pos", 32'(pos), 32'd5);
      check("restart_rd", r, 32'h6745_2301);
      issue(32'hCAFE_F00D, 5'd5);
      repeat (2) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clock);
         if (bus.done) pulses++;
      end
      check("reset_abort_pulses", 32'(pulses), 32'd0);
      check("reset_abort_rd", bus.rd, 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
